jtkcpu_stack_seq: RTL and testbench
===================================

# jtkcpu_stack_seq

Push/pull sequencer for the JTKCPU register file. It takes an 8-bit register mask from the instruction decoder and walks it one byte at a time. For each byte it drives the register-file select (one-hot register bit plus high/low byte flag), the stack-pointer decrement/increment strobes and the memory bus request. It sits between the decoder/microsequencer and the register file/bus interface, and is used by PSHS/PSHU/PULS/PULU as well as by interrupt entry and RTI.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin sequence; sampled only in IDLE
- pull  in  1  0 = push, 1 = pull; latched at start
- ussel  in  1  0 = S stack, 1 = U stack; latched at start
- mask  in  8  register mask; latched at start
  - bit0 = CC, bit1 = A, bit2 = B, bit3 = DP (8-bit)
  - bit4 = X, bit5 = Y, bit6 = other stack pointer, bit7 = PC (16-bit)
- bus_ack  in  1  memory transfer completes this cycle (may be high in the same cycle as bus_req)
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- reg_sel  out  8  one-hot register currently transferred; 0 when idle
- hilon  out  1  1 = high byte of a 16-bit register; always 0 for 8-bit registers
- ussel_q  out  1  latched stack select
- sp_dec  out  1  decrement selected stack pointer by 1 this cycle
- sp_inc  out  1  increment selected stack pointer by 1 this cycle
- pul_en  out  1  write the read byte into reg_sel/hilon this cycle
- bus_req  out  1  memory access request at current stack pointer
- bus_we  out  1  1 = write (push), 0 = read (pull); valid with bus_req

## Operation
- Reset: state IDLE, latched mask = 0, and every output 0.
- States: IDLE, PDEC, PWR, PRD, DONE.
- IDLE + start:
  - Latch mask, pull and ussel.
  - pull = 0 → PDEC. pull = 1 → PRD. mask = 0 → DONE directly.
  - start is ignored in every other state.
- Register order:
  - Push: highest set bit first (PC, U/S, Y, X, DP, B, A, CC).
  - Pull: lowest set bit first (CC, A, B, DP, X, Y, U/S, PC).
- Byte order for 16-bit registers:
  - Push: low byte (hilon = 0), then high byte (hilon = 1).
  - Pull: high byte, then low byte.
  - This places the high byte at the lower address.
- PDEC: sp_dec = 1 for exactly one cycle → PWR.
- PWR: bus_req = 1, bus_we = 1; held until bus_ack. On the ack cycle, advance to the next byte:
  - If more bytes remain → PDEC.
  - Otherwise → DONE.
- PRD: bus_req = 1, bus_we = 0; held until bus_ack. On the ack cycle, pul_en = 1 and sp_inc = 1 together, then advance:
  - If more bytes remain → PRD.
  - Otherwise → DONE.
- Advance rule:
  - 16-bit register: toggle hilon after its first byte.
  - After a register's last byte, clear its bit in the latched mask and reset the byte flag.
- DONE: done = 1, busy = 0, reg_sel = 0 → IDLE.
- busy = 1 in PDEC, PWR and PRD only.
- reg_sel and hilon are stable for the whole byte, including PDEC and all wait cycles.
- sp_dec, sp_inc and pul_en are never asserted outside the states listed above, and never together with each other except sp_inc with pul_en.
- Reset mid-sequence: back to IDLE immediately. No further bus_req or strobes are issued, and any partially completed push is abandoned.

## Timing
- start sampled at edge 0; first active cycle is cycle 1.
- Zero-wait bus (bus_ack tied high):
  - Push of n bytes: 2n busy cycles; done in cycle 2n+1.
  - Pull of n bytes: n busy cycles; done in cycle n+1.
- Each wait cycle (bus_req high, bus_ack low) extends the sequence by one cycle. Outputs are held unchanged during waits.
- Byte count: 8-bit registers = 1 byte each; 16-bit registers = 2 bytes each. Maximum 12 bytes (mask 0xFF).
- A new start is accepted no earlier than the cycle after DONE, i.e. in IDLE.
- All outputs are registered or decoded from state only. No combinational path from bus_ack to bus_req.

## Test plan
- Push mask 0x81, ussel = 0, ack high:
  - Cycles 1-6 show reg_sel/hilon = 80/0, 80/1, 01/0, with sp_dec in cycles 1, 3, 5 and bus_req+bus_we in cycles 2, 4, 6.
  - done in cycle 7.
- Pull mask 0x81, ack high:
  - Cycles 1-3 show reg_sel/hilon = 01/0, 80/1, 80/0, with pul_en and sp_inc in each cycle.
  - done in cycle 4, busy low in cycle 4.
- Pull mask 0x12 with bus_ack low for 2 cycles on every byte:
  - 3 bytes × 3 cycles = 9 busy cycles; done in cycle 10.
  - pul_en is asserted only on ack cycles; reg_sel is held through waits.
- Mask 0x00 with start, either direction:
  - done in cycle 1; bus_req, sp_dec and sp_inc stay 0 throughout.
- Push mask 0xFF, ussel = 1:
  - 12 writes; reg_sel order 80, 80, 40, 40, 20, 20, 10, 10, 08, 04, 02, 01; ussel_q = 1 throughout.
  - Exactly 12 sp_dec pulses; done in cycle 25.
  - A second start asserted mid-sequence is ignored.
- Assert rst during the 3rd byte of a mask 0xF0 push:
  - All outputs are 0 immediately.
  - After rst release, start with mask 0x02 pull: exactly one read, reg_sel = 02, done in cycle 2.

Source files
------------

// File: rtl/jtkcpu_stack_seq.sv
// jtkcpu_stack_seq
// Push/pull sequencer for the JTKCPU register file. Walks an 8-bit register
// mask one byte at a time, driving the register-file select, stack-pointer
// strobes and the memory bus request. Used by PSHS/PSHU/PULS/PULU, interrupt
// entry and RTI.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           begin a sequence (only honoured in IDLE)
//   pull            0 = push, 1 = pull (latched at start)
//   ussel           0 = S stack, 1 = U stack (latched at start)
//   mask[7:0]       register mask (latched at start)
//                   bit0 CC, bit1 A, bit2 B, bit3 DP (8-bit)
//                   bit4 X, bit5 Y, bit6 other SP, bit7 PC (16-bit)
//   bus_ack         memory transfer completes this cycle
//   busy            sequence in progress (PDEC/PWR/PRD)
//   done            one-cycle completion pulse
//   reg_sel[7:0]    one-hot register being transferred, 0 when idle
//   hilon           high byte of a 16-bit register
//   ussel_q         latched stack select
//   sp_dec, sp_inc  stack pointer decrement / increment strobes
//   pul_en          write the read byte into reg_sel/hilon
//   bus_req, bus_we memory request and write enable
//
// All outputs except pul_en/sp_inc are decoded from registered state only;
// pul_en/sp_inc qualify the read with bus_ack in the ack cycle itself.
module jtkcpu_stack_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pull,
  input  logic       ussel,
  input  logic [7:0] mask,
  input  logic       bus_ack,
  output logic       busy,
  output logic       done,
  output logic [7:0] reg_sel,
  output logic       hilon,
  output logic       ussel_q,
  output logic       sp_dec,
  output logic       sp_inc,
  output logic       pul_en,
  output logic       bus_req,
  output logic       bus_we
);

  localparam int unsigned MASK_W = 8;
  localparam logic [MASK_W-1:0] WIDE_REGS = 8'hF0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PDEC = 3'd1,
    PWR  = 3'd2,
    PRD  = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic              pull_q, pull_d;
  logic              ussel_d;
  // Set once the first byte of a 16-bit register has been transferred
  logic              second_q, second_d;

  logic [MASK_W-1:0] cur_sel;
  logic [MASK_W-1:0] rest;
  logic              cur_wide;
  logic              last_byte;
  logic              more;

  // Highest set bit: push order PC first down to CC
  function automatic logic [MASK_W-1:0] pick_high(input logic [MASK_W-1:0] m);
    logic [MASK_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(MASK_W); i++) begin
      if (m[i]) r = MASK_W'(1) << i;
    end
    return r;
  endfunction

  // Lowest set bit: pull order CC first up to PC
  function automatic logic [MASK_W-1:0] pick_low(input logic [MASK_W-1:0] m);
    logic [MASK_W-1:0] r;
    r = '0;
    for (int i = int'(MASK_W) - 1; i >= 0; i--) begin
      if (m[i]) r = MASK_W'(1) << i;
    end
    return r;
  endfunction

  // Current register and what remains after it
  always_comb begin
    cur_sel   = pull_q ? pick_low(mask_q) : pick_high(mask_q);
    cur_wide  = |(cur_sel & WIDE_REGS);
    last_byte = !cur_wide || second_q;
    rest      = mask_q & ~cur_sel;
    more      = !last_byte || (rest != '0);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      pull_q   <= 1'b0;
      ussel_q  <= 1'b0;
      second_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      pull_q   <= pull_d;
      ussel_q  <= ussel_d;
      second_q <= second_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    pull_d   = pull_q;
    ussel_d  = ussel_q;
    second_d = second_q;
    busy     = 1'b0;
    done     = 1'b0;
    sp_dec   = 1'b0;
    sp_inc   = 1'b0;
    pul_en   = 1'b0;
    bus_req  = 1'b0;
    bus_we   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d   = mask;
          pull_d   = pull;
          ussel_d  = ussel;
          second_d = 1'b0;
          if (mask == '0)  state_d = DONE;
          else if (pull)   state_d = PRD;
          else             state_d = PDEC;
        end
      end
      PDEC: begin
        busy    = 1'b1;
        sp_dec  = 1'b1;
        state_d = PWR;
      end
      PWR: begin
        busy    = 1'b1;
        bus_req = 1'b1;
        bus_we  = 1'b1;
        if (bus_ack) begin
          state_d = more ? PDEC : DONE;
        end
      end
      PRD: begin
        busy    = 1'b1;
        bus_req = 1'b1;
        pul_en  = bus_ack;
        sp_inc  = bus_ack;
        if (bus_ack) begin
          state_d = more ? PRD : DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Byte advance on a completed transfer
    if ((state_q == PWR || state_q == PRD) && bus_ack) begin
      if (last_byte) begin
        mask_d   = rest;
        second_d = 1'b0;
      end else begin
        second_d = 1'b1;
      end
    end
  end

  // Push sends low byte first, pull takes high byte first
  assign reg_sel = busy ? cur_sel : '0;
  assign hilon   = busy & cur_wide & (second_q ^ pull_q);

endmodule

// File: tb/tb_jtkcpu_stack_seq.sv
// Scoreboard bench for jtkcpu_stack_seq: stimulus pushes one expected output
// record per active cycle; a negedge monitor pops and compares.
module tb_jtkcpu_stack_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic       pull;
  logic       ussel;
  logic [7:0] mask;
  logic       bus_ack;
  logic       busy;
  logic       done;
  logic [7:0] reg_sel;
  logic       hilon;
  logic       ussel_q;
  logic       sp_dec;
  logic       sp_inc;
  logic       pul_en;
  logic       bus_req;
  logic       bus_we;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [7:0] sel;
    logic       hi;
    logic       us;
    logic       dec;
    logic       inc;
    logic       pen;
    logic       req;
    logic       we;
  } obs_t;

  obs_t       exp_q[$];
  logic [8:0] byte_q[$];
  obs_t       dut_obs;
  int         checks;
  int         errors;

  jtkcpu_stack_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pull    (pull),
    .ussel   (ussel),
    .mask    (mask),
    .bus_ack (bus_ack),
    .busy    (busy),
    .done    (done),
    .reg_sel (reg_sel),
    .hilon   (hilon),
    .ussel_q (ussel_q),
    .sp_dec  (sp_dec),
    .sp_inc  (sp_inc),
    .pul_en  (pul_en),
    .bus_req (bus_req),
    .bus_we  (bus_we)
  );

  assign dut_obs = {busy, done, reg_sel, hilon, ussel_q, sp_dec, sp_inc, pul_en, bus_req, bus_we};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic b, input logic d, input logic [7:0] s,
                              input logic h, input logic u, input logic dc,
                              input logic ic, input logic pe, input logic rq,
                              input logic we);
    return {b, d, s, h, u, dc, ic, pe, rq, we};
  endfunction

  // Monitor: compare every expected cycle; flag activity nobody expected
  always @(negedge clk) begin
    obs_t e;
    logic act;
    if (!rst) begin
      act = busy | done | bus_req | sp_dec | sp_inc | pul_en | (|reg_sel) | hilon;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (dut_obs !== e) begin
          errors++;
          $display("FAIL cycle_obs t=%0t got busy,done,sel,hi,us,dec,inc,pen,req,we=%b,%b,%h,%b,%b,%b,%b,%b,%b,%b expected %b,%b,%h,%b,%b,%b,%b,%b,%b,%b",
                   $time, dut_obs.busy, dut_obs.done, dut_obs.sel, dut_obs.hi, dut_obs.us,
                   dut_obs.dec, dut_obs.inc, dut_obs.pen, dut_obs.req, dut_obs.we,
                   e.busy, e.done, e.sel, e.hi, e.us, e.dec, e.inc, e.pen, e.req, e.we);
        end
      end else if (act) begin
        checks++;
        errors++;
        $display("FAIL unexpected_activity t=%0t got %b expected idle outputs", $time, dut_obs);
      end
    end
  end

  task automatic step(input logic ack, input obs_t e);
    bus_ack = ack;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic add_byte(input logic [7:0] sel, input logic hi);
    byte_q.push_back({hi, sel});
  endtask

  // Run one sequence over the hand-written byte list in byte_q
  task automatic run_seq(input logic p, input logic us, input logic [7:0] m,
                         input int waits, input logic spam);
    logic [7:0] sel;
    logic       hi;
    start   = 1'b1;
    pull    = p;
    ussel   = us;
    mask    = m;
    bus_ack = 1'b0;
    @(posedge clk);
    #1;
    // Scramble inputs to prove they were latched; optionally re-assert start
    start = spam;
    pull  = ~p;
    ussel = ~us;
    mask  = ~m;
    for (int k = 0; k < byte_q.size(); k++) begin
      sel = byte_q[k][7:0];
      hi  = byte_q[k][8];
      if (!p) step(1'b1, mk(1'b1, 1'b0, sel, hi, us, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      for (int w = 0; w < waits; w++)
        step(1'b0, mk(1'b1, 1'b0, sel, hi, us, 1'b0, 1'b0, 1'b0, 1'b1, !p));
      step(1'b1, mk(1'b1, 1'b0, sel, hi, us, 1'b0, p, p, 1'b1, !p));
    end
    start = 1'b0;
    step(1'b0, mk(1'b0, 1'b1, 8'h00, 1'b0, us, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    byte_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t got no completion expected finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    pull    = 1'b0;
    ussel   = 1'b0;
    mask    = 8'h00;
    bus_ack = 1'b0;
    #3;
    checks++;
    if (dut_obs !== '0) begin
      errors++;
      $display("FAIL reset_state got %b expected all zero", dut_obs);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Push PC then CC, zero-wait
    add_byte(8'h80, 1'b0); add_byte(8'h80, 1'b1); add_byte(8'h01, 1'b0);
    run_seq(1'b0, 1'b0, 8'h81, 0, 1'b0);

    // Pull CC then PC (high byte first)
    add_byte(8'h01, 1'b0); add_byte(8'h80, 1'b1); add_byte(8'h80, 1'b0);
    run_seq(1'b1, 1'b0, 8'h81, 0, 1'b0);

    // Pull A and X with two wait cycles per byte
    add_byte(8'h02, 1'b0); add_byte(8'h10, 1'b1); add_byte(8'h10, 1'b0);
    run_seq(1'b1, 1'b0, 8'h12, 2, 1'b0);

    // Push Y and X on U stack with one wait per write
    add_byte(8'h20, 1'b0); add_byte(8'h20, 1'b1);
    add_byte(8'h10, 1'b0); add_byte(8'h10, 1'b1);
    run_seq(1'b0, 1'b1, 8'h30, 1, 1'b0);

    // Empty mask, both directions
    run_seq(1'b0, 1'b0, 8'h00, 0, 1'b0);
    run_seq(1'b1, 1'b1, 8'h00, 0, 1'b0);

    // Full push on U stack with start held during the sequence
    add_byte(8'h80, 1'b0); add_byte(8'h80, 1'b1);
    add_byte(8'h40, 1'b0); add_byte(8'h40, 1'b1);
    add_byte(8'h20, 1'b0); add_byte(8'h20, 1'b1);
    add_byte(8'h10, 1'b0); add_byte(8'h10, 1'b1);
    add_byte(8'h08, 1'b0); add_byte(8'h04, 1'b0);
    add_byte(8'h02, 1'b0); add_byte(8'h01, 1'b0);
    run_seq(1'b0, 1'b1, 8'hFF, 0, 1'b1);

    // Reset during the write of the third byte of a 0xF0 push
    start = 1'b1; pull = 1'b0; ussel = 1'b0; mask = 8'hF0; bus_ack = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    step(1'b1, mk(1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    step(1'b1, mk(1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    step(1'b1, mk(1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    step(1'b1, mk(1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    step(1'b1, mk(1'b1, 1'b0, 8'h40, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    bus_ack = 1'b0;
    rst     = 1'b1;
    #1;
    checks++;
    if (dut_obs !== '0) begin
      errors++;
      $display("FAIL reset_mid_seq got %b expected all zero", dut_obs);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single-byte pull after reset
    add_byte(8'h02, 1'b0);
    run_seq(1'b1, 1'b0, 8'h02, 0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expect got %0d entries expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
